game_controller: RTL and testbench
==================================

# game_controller

Top-level game-flow state machine that sits downstream of the player block and the enemy blocks. It consumes the player's `player_dead` and the enemies' `enemies_dead` flags, and drives the shared `game_enable` gate and a per-level soft reset. It also tracks the current level and decodes the screen-message selects for title, level-clear, game-over and win. A start key is decoded directly from the keyboard `keyCode`/`make` stream.

## Interface
Parameters:
- KEYCODE_WIDTH, 9, width of keyboard scan code
- START_KEY, 9'h029, scan code that starts or restarts the game (space)
- LEVEL_AMOUNT, 3, number of levels; clearing the last one wins
- LEVEL_WIDTH, 2, width of level index
- CLEAR_PAUSE_FRAMES, 120, frames spent in LEVEL_CLEAR
- END_PAUSE_FRAMES, 180, frames before a restart is accepted in GAME_OVER/WIN
- PAUSE_WIDTH, 8, frame-counter width; must hold max(CLEAR_PAUSE_FRAMES, END_PAUSE_FRAMES)

Ports:
- clk  in  1  system clock; one clock domain
- resetN  in  1  asynchronous, active-low reset
- keyCode  in  KEYCODE_WIDTH  keyboard scan code
- make  in  1  one-cycle key-press strobe
- startOfFrame  in  1  one-cycle pulse per video frame
- player_dead  in  1  level-sensitive; player out of lives
- enemies_dead  in  1  level-sensitive; all enemies of the level destroyed
- game_enable  out  1  high only in PLAYING; gates startOfFrame for the player and enemies
- level_resetN  out  1  active-low; low for exactly one cycle in LOAD
- level  out  LEVEL_WIDTH  current level index, 0-based
- show_title, show_level_clear, show_game_over, show_win  out  1 each  one-hot message selects

## Operation
- start_pulse = make && (keyCode == START_KEY), same cycle, not registered. A repeated make from a held key counts as a new press.
- States: IDLE, LOAD, PLAYING, LEVEL_CLEAR, GAME_OVER, WIN.
- IDLE: show_title=1. On start_pulse: level<=0, go to LOAD.
- LOAD: level_resetN=0 for one cycle, pause counter cleared, unconditional transition to PLAYING.
- PLAYING: game_enable=1.
  - player_dead=1 -> GAME_OVER.
  - Otherwise, enemies_dead=1 -> WIN if level==LEVEL_AMOUNT-1, else LEVEL_CLEAR.
  - Simultaneous player_dead and enemies_dead -> GAME_OVER (death wins).
- LEVEL_CLEAR: show_level_clear=1.
  - The counter increments on each startOfFrame.
  - On the startOfFrame where counter==CLEAR_PAUSE_FRAMES-1: level<=level+1, go to LOAD.
- GAME_OVER / WIN: show_game_over or show_win=1.
  - The counter increments on startOfFrame and saturates at END_PAUSE_FRAMES.
  - start_pulse is accepted only when counter==END_PAUSE_FRAMES: level<=0, go to LOAD. An earlier start_pulse is ignored, not queued.
- player_dead and enemies_dead are ignored outside PLAYING. Both stay high until level_resetN clears the producers.
- start_pulse is ignored in LOAD, PLAYING and LEVEL_CLEAR.
- Output decoding: all outputs are combinational from state/level registers, glitch-free w.r.t. clk. Exactly one show_* is high in IDLE/LEVEL_CLEAR/GAME_OVER/WIN. None is high in LOAD or PLAYING.

## Timing
- Values during reset: state=IDLE, level=0, counter=0. Outputs: game_enable=0, level_resetN=1, show_title=1, other show_*=0.
- start_pulse at cycle n -> LOAD in n+1 (level_resetN low during n+1) -> PLAYING in n+2 (game_enable high from n+2).
- player_dead/enemies_dead high at cycle n in PLAYING -> game_enable low from n+1.
- LEVEL_CLEAR lasts exactly CLEAR_PAUSE_FRAMES startOfFrame pulses after entry, plus one cycle, then LOAD.
- A startOfFrame coincident with the entry cycle into LEVEL_CLEAR is not counted; counting starts the cycle after entry.
- Asynchronous reset mid-operation returns to IDLE immediately. Consumers still use resetN for their own reset and AND it with level_resetN.

## Structure
- Shared package game_pkg:
  - typedef enum logic [2:0] game_state_t {IDLE, LOAD, PLAYING, LEVEL_CLEAR, GAME_OVER, WIN}.
  - START_KEY constant.
- Sub-module frame_counter:
  - counts startOfFrame pulses;
  - has synchronous clear and a saturate-at-limit input;
  - outputs count and reached.
- The FSM, level register and start-key decode stay in game_controller.

## Test plan
- Reset, then keyCode=9'h029 with make=1 for one cycle: level_resetN low exactly 1 cycle at n+1; game_enable=1 from n+2; level=0; show_title drops at n+1.
- In PLAYING at level 0, enemies_dead=1: LEVEL_CLEAR; after 120 startOfFrame pulses -> LOAD, level=1, then PLAYING.
- At level 2, enemies_dead=1 -> WIN, show_win=1. Start press after 50 frames is ignored; press after 180 frames -> LOAD, level=0.
- In PLAYING, player_dead and enemies_dead rise in the same cycle -> GAME_OVER, level unchanged, show_game_over=1.
- Start key pressed during PLAYING and LEVEL_CLEAR -> no state change. A non-start key (9'h06C) pressed in IDLE -> stays IDLE.
- resetN asserted mid-LEVEL_CLEAR at level 1 -> immediately IDLE, level=0, show_title=1, game_enable=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAYING,
        LEVEL_CLEAR,
        GAME_OVER,
        WIN
    } game_state_t;

    localparam logic [8:0] START_KEY = 9'h029;

endpackage

// File: rtl/frame_counter.sv
// Counts startOfFrame pulses; optional saturation at the limit, synchronous clear.
module frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             tick,
    input  logic             saturate,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             reached
);

    assign reached = (count == limit);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !(saturate && reached)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game-flow FSM: start key decode, level tracking, pause timing and message selects.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   IDLE        | title screen, waiting for the start key
//   LOAD        | one-cycle level soft reset, pause counter cleared
//   PLAYING     | game_enable high, watching player/enemy status
//   LEVEL_CLEAR | level-clear message for CLEAR_PAUSE_FRAMES frames
//   GAME_OVER   | game-over message, restart after END_PAUSE_FRAMES frames
//   WIN         | win message, restart after END_PAUSE_FRAMES frames
module game_controller #(
    parameter int                       KEYCODE_WIDTH      = 9,
    parameter logic [KEYCODE_WIDTH-1:0] START_KEY          = game_pkg::START_KEY,
    parameter int                       LEVEL_AMOUNT       = 3,
    parameter int                       LEVEL_WIDTH        = 2,
    parameter int                       CLEAR_PAUSE_FRAMES = 120,
    parameter int                       END_PAUSE_FRAMES   = 180,
    parameter int                       PAUSE_WIDTH        = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [KEYCODE_WIDTH-1:0] keyCode,
    input  logic                     make,
    input  logic                     startOfFrame,
    input  logic                     player_dead,
    input  logic                     enemies_dead,
    output logic                     game_enable,
    output logic                     level_resetN,
    output logic [LEVEL_WIDTH-1:0]   level,
    output logic                     show_title,
    output logic                     show_level_clear,
    output logic                     show_game_over,
    output logic                     show_win
);
    import game_pkg::*;

    localparam logic [PAUSE_WIDTH-1:0] CLEAR_LIMIT = PAUSE_WIDTH'(CLEAR_PAUSE_FRAMES - 1);
    localparam logic [PAUSE_WIDTH-1:0] END_LIMIT   = PAUSE_WIDTH'(END_PAUSE_FRAMES);
    localparam logic [LEVEL_WIDTH-1:0] LAST_LEVEL  = LEVEL_WIDTH'(LEVEL_AMOUNT - 1);

    game_state_t            state;
    logic                   startPulse;
    logic                   pausing;
    logic                   pauseTick;
    logic                   pauseSaturate;
    logic [PAUSE_WIDTH-1:0] pauseLimit;
    logic [PAUSE_WIDTH-1:0] pauseCount;
    logic                   pauseReached;
    logic                   restartReady;

    assign startPulse    = make && (keyCode == START_KEY);
    assign pausing       = (state == LEVEL_CLEAR) || (state == GAME_OVER) || (state == WIN);
    assign pauseTick     = startOfFrame && pausing;
    // LEVEL_CLEAR exits on the pulse that would make the count reach the full pause,
    // so it compares against one less and never needs to saturate.
    assign pauseSaturate = (state != LEVEL_CLEAR);
    assign pauseLimit    = (state == LEVEL_CLEAR) ? CLEAR_LIMIT : END_LIMIT;
    assign restartReady  = (pauseCount == END_LIMIT);

    frame_counter #(
        .WIDTH(PAUSE_WIDTH)
    ) u_frameCounter (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (state == LOAD),
        .tick     (pauseTick),
        .saturate (pauseSaturate),
        .limit    (pauseLimit),
        .count    (pauseCount),
        .reached  (pauseReached)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            level <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startPulse) begin
                        level <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= PLAYING;
                end
                PLAYING: begin
                    if (player_dead) begin
                        state <= GAME_OVER;
                    end else if (enemies_dead) begin
                        state <= (level == LAST_LEVEL) ? WIN : LEVEL_CLEAR;
                    end
                end
                LEVEL_CLEAR: begin
                    if (startOfFrame && pauseReached) begin
                        level <= level + 1'b1;
                        state <= LOAD;
                    end
                end
                GAME_OVER, WIN: begin
                    if (startPulse && restartReady) begin
                        level <= '0;
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign game_enable      = (state == PLAYING);
    assign level_resetN     = (state != LOAD);
    assign show_title       = (state == IDLE);
    assign show_level_clear = (state == LEVEL_CLEAR);
    assign show_game_over   = (state == GAME_OVER);
    assign show_win         = (state == WIN);

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: behavioural game-flow model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_game_controller;

    localparam logic [8:0] KEY_START = 9'h029;
    localparam logic [8:0] KEY_OTHER = 9'h06C;
    localparam int N_LEVELS = 3;
    localparam int CLEAR_FRAMES = 120;
    localparam int END_FRAMES = 180;

    // model phases
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_PLAY  = 2;
    localparam int M_CLEAR = 3;
    localparam int M_OVER  = 4;
    localparam int M_WIN   = 5;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [8:0] keyCode = '0;
    logic       make = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       player_dead = 1'b0;
    logic       enemies_dead = 1'b0;
    logic       game_enable;
    logic       level_resetN;
    logic [1:0] level;
    logic       show_title;
    logic       show_level_clear;
    logic       show_game_over;
    logic       show_win;

    int checks = 0;
    int failures = 0;

    int mPhase = M_IDLE;
    int mLevel = 0;
    int mFrames = 0;
    int nPhase, nLevel, nFrames;

    always #5 clk = ~clk;

    game_controller dut (
        .clk              (clk),
        .resetN           (resetN),
        .keyCode          (keyCode),
        .make             (make),
        .startOfFrame     (startOfFrame),
        .player_dead      (player_dead),
        .enemies_dead     (enemies_dead),
        .game_enable      (game_enable),
        .level_resetN     (level_resetN),
        .level            (level),
        .show_title       (show_title),
        .show_level_clear (show_level_clear),
        .show_game_over   (show_game_over),
        .show_win         (show_win)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        check("game_enable", int'(game_enable), int'(mPhase == M_PLAY));
        check("level_resetN", int'(level_resetN), int'(mPhase != M_LOAD));
        check("level", int'(level), mLevel);
        check("show_title", int'(show_title), int'(mPhase == M_IDLE));
        check("show_level_clear", int'(show_level_clear), int'(mPhase == M_CLEAR));
        check("show_game_over", int'(show_game_over), int'(mPhase == M_OVER));
        check("show_win", int'(show_win), int'(mPhase == M_WIN));
    endtask

    // Game rules applied to one clock edge with the inputs currently driven.
    task automatic modelStep();
        bit start;
        start = make && (keyCode == KEY_START);
        nPhase = mPhase;
        nLevel = mLevel;
        nFrames = mFrames;
        case (mPhase)
            M_IDLE: if (start) begin nLevel = 0; nPhase = M_LOAD; end
            M_LOAD: begin nFrames = 0; nPhase = M_PLAY; end
            M_PLAY: begin
                if (player_dead) nPhase = M_OVER;
                else if (enemies_dead) nPhase = (mLevel == N_LEVELS - 1) ? M_WIN : M_CLEAR;
            end
            M_CLEAR: begin
                if (startOfFrame) begin
                    nFrames = mFrames + 1;
                    if (nFrames == CLEAR_FRAMES) begin
                        nLevel = mLevel + 1;
                        nPhase = M_LOAD;
                    end
                end
            end
            default: begin
                if (start && mFrames >= END_FRAMES) begin
                    nLevel = 0;
                    nPhase = M_LOAD;
                end else if (startOfFrame && mFrames < END_FRAMES) begin
                    nFrames = mFrames + 1;
                end
            end
        endcase
    endtask

    // Entered and left at a negedge; checks the outputs after the edge.
    task automatic tick(input logic mk, input logic [8:0] kc, input logic sof,
                        input logic pd, input logic ed);
        make = mk;
        keyCode = kc;
        startOfFrame = sof;
        player_dead = pd;
        enemies_dead = ed;
        modelStep();
        @(posedge clk);
        #1;
        mPhase = nPhase;
        mLevel = nLevel;
        mFrames = nFrames;
        @(negedge clk);
        compareAll();
    endtask

    task automatic doReset();
        resetN = 1'b0;
        #1;
        mPhase = M_IDLE;
        mLevel = 0;
        mFrames = 0;
        compareAll();
        @(negedge clk);
        compareAll();
        resetN = 1'b1;
        make = 1'b0;
        startOfFrame = 1'b0;
        player_dead = 1'b0;
        enemies_dead = 1'b0;
    endtask

    task automatic clearLevel();
        tick(0, '0, 1, 0, 1);
        repeat (CLEAR_FRAMES) tick(0, '0, 1, 0, 1);
        tick(0, '0, 0, 0, 0);
    endtask

    initial begin
        bit pdHold, edHold;
        logic mk, sof;
        logic [8:0] kc;

        @(negedge clk);
        @(negedge clk);
        compareAll();
        check("reset_title", int'(show_title), 1);
        check("reset_enable", int'(game_enable), 0);
        check("reset_lvlrst", int'(level_resetN), 1);
        resetN = 1'b1;

        // start press -> LOAD for one cycle -> PLAYING
        tick(1, KEY_START, 0, 0, 0);
        check("start_lvlrst_low", int'(level_resetN), 0);
        check("start_title_drop", int'(show_title), 0);
        tick(0, '0, 0, 0, 0);
        check("start_playing", int'(game_enable), 1);
        check("start_lvlrst_high", int'(level_resetN), 1);
        check("start_level0", int'(level), 0);
        tick(1, KEY_START, 0, 0, 0);
        check("start_in_play", int'(game_enable), 1);

        // level 0 clear: coincident frame at entry not counted
        tick(0, '0, 1, 0, 1);
        check("clear_entered", int'(show_level_clear), 1);
        tick(1, KEY_START, 1, 0, 1);
        repeat (CLEAR_FRAMES - 2) tick(0, '0, 1, 0, 1);
        check("clear_119_frames", int'(show_level_clear), 1);
        tick(0, '0, 1, 0, 1);
        check("clear_load", int'(level_resetN), 0);
        check("clear_level1", int'(level), 1);
        tick(0, '0, 0, 0, 0);
        check("clear_play_l1", int'(game_enable), 1);

        clearLevel();
        check("level2", int'(level), 2);

        // last level -> WIN, restart only after the full end pause
        tick(0, '0, 0, 0, 1);
        check("win_shown", int'(show_win), 1);
        repeat (50) tick(0, '0, 1, 0, 1);
        tick(1, KEY_START, 0, 0, 1);
        check("win_early_start", int'(show_win), 1);
        repeat (END_FRAMES - 51) tick(0, '0, 1, 0, 1);
        tick(1, KEY_START, 0, 0, 1);
        check("win_179_start", int'(show_win), 1);
        tick(0, '0, 1, 0, 1);
        tick(1, KEY_START, 0, 0, 1);
        check("win_restart_load", int'(level_resetN), 0);
        check("win_restart_lvl0", int'(level), 0);
        tick(0, '0, 0, 0, 0);

        // simultaneous death and clear at level 1 -> GAME_OVER
        clearLevel();
        tick(0, '0, 0, 1, 1);
        check("over_shown", int'(show_game_over), 1);
        check("over_level_kept", int'(level), 1);
        repeat (END_FRAMES) tick(0, '0, 1, 1, 1);
        tick(1, KEY_START, 0, 1, 1);
        tick(0, '0, 0, 0, 0);

        // reset in the middle of LEVEL_CLEAR at level 1
        clearLevel();
        tick(0, '0, 1, 0, 1);
        repeat (30) tick(0, '0, 1, 0, 1);
        doReset();
        check("rst_title", int'(show_title), 1);
        check("rst_level", int'(level), 0);
        check("rst_enable", int'(game_enable), 0);

        tick(1, KEY_OTHER, 0, 0, 0);
        check("other_key_idle", int'(show_title), 1);

        // randomized play
        pdHold = 0;
        edHold = 0;
        for (int c = 0; c < 20000; c++) begin
            if (mPhase == M_LOAD) begin
                pdHold = 0;
                edHold = 0;
            end else if (mPhase == M_PLAY) begin
                if ($urandom_range(0, 299) == 0) pdHold = 1;
                if ($urandom_range(0, 39) == 0) edHold = 1;
            end
            mk = ($urandom_range(0, 5) == 0);
            kc = $urandom_range(0, 1) ? KEY_START : 9'($urandom_range(0, 511));
            sof = $urandom_range(0, 1) ? 1'b1 : 1'b0;
            tick(mk, kc, sof, pdHold, edHold);
            if ($urandom_range(0, 3999) == 0) begin
                doReset();
                pdHold = 0;
                edHold = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
